// File: rtl/layer_conv_param.sv
// layer_conv_param: binary-activation conv pixel accumulator with 2x2 window readout; define LAYER_CONV_MAXPOOL_EN for max-pooled output
module layer_conv_param #(
  parameter int CH = 2,
  parameter int TAPS = 9,
  parameter int WGT_W = 9,
  parameter int ACC_W = 18,
  parameter int MAP_W = 26,
  parameter int MAP_H = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic strt,
  input  logic din,
  input  logic tx_done,
  output logic [$clog2(TAPS)-1:0] w_addr,
  input  logic [CH*WGT_W-1:0] w_data,
  input  logic [CH*WGT_W-1:0] bias,
  input  logic bsy_in,
  output logic bsy_out,
  output logic rdy,
  output logic vld_out,
  output logic [CH*ACC_W-1:0] dout
);
  localparam int AW = $clog2(TAPS);
  localparam int DEPTH = MAP_W * MAP_H;
  localparam int RI = $clog2(DEPTH);
  localparam int RA = $clog2(DEPTH + 1);
  localparam int EW = (ACC_W > WGT_W ? ACC_W : WGT_W) + AW + 2;
  localparam logic signed [EW-1:0] MAXV = {{(EW - ACC_W + 1){1'b0}}, {(ACC_W - 1){1'b1}}};
  typedef enum logic {IDLE, ACC} ws_t;
  typedef enum logic [2:0] {INI, P0, P1, P2, P3, DONE} rs_t;
  ws_t ws, ws_n;
  rs_t rs, rs_n;
  logic signed [EW-1:0] acc [CH];
  logic signed [EW-1:0] acc_n [CH];
  logic signed [EW-1:0] sum [CH];
  logic [CH*ACC_W-1:0] wr_data, q;
  logic [CH*ACC_W-1:0] ram [DEPTH];
  logic [RA-1:0] addr_wr, base, col, nb, rd_addr;
  logic start, last, rd;
  assign start = ws == IDLE && strt && addr_wr < RA'(DEPTH);
  assign last = ws == ACC && w_addr == AW'(TAPS - 1);
  assign bsy_out = ws == ACC;
  always_comb ws_n = tx_done ? IDLE : start ? ACC : last ? IDLE : ws;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ws <= IDLE;
    else ws <= ws_n;
  // accumulator is wider than ACC_W so the final clamp sees the true sum
  always_comb begin
    wr_data = '0;
    for (int c = 0; c < CH; c++) begin
      acc_n[c] = din ? acc[c] + EW'($signed(w_data[c*WGT_W +: WGT_W]))
                     : acc[c] - EW'($signed(w_data[c*WGT_W +: WGT_W]));
      sum[c] = acc_n[c] + EW'($signed(bias[c*WGT_W +: WGT_W]));
      wr_data[c*ACC_W +: ACC_W] = (sum[c][EW-1] || sum[c] == '0) ? '0
                                : sum[c] > MAXV ? MAXV[ACC_W-1:0] : sum[c][ACC_W-1:0];
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      w_addr <= '0;
      addr_wr <= '0;
      for (int c = 0; c < CH; c++) acc[c] <= '0;
    end else if (tx_done || start || last) begin
      w_addr <= '0;
      for (int c = 0; c < CH; c++) acc[c] <= '0;
      addr_wr <= tx_done ? '0 : addr_wr + RA'(last);
    end else if (ws == ACC) begin
      w_addr <= w_addr + 1'b1;
      for (int c = 0; c < CH; c++) acc[c] <= acc_n[c];
    end
  always_ff @(posedge clk) begin
    if (last && !tx_done) ram[addr_wr[RI-1:0]] <= wr_data;
    q <= ram[rd_addr[RI-1:0]];
  end
  assign nb = col == RA'(MAP_W / 2 - 1) ? base + RA'(MAP_W + 2) : base + RA'(2);
  assign rdy = ({1'b0, base} + (RA + 1)'(MAP_W + 1)) < {1'b0, addr_wr};
  assign rd = rs == P0 || rs == P1 || rs == P2 || rs == P3;
  assign rd_addr = base + (rs == P1 ? RA'(1) : rs == P2 ? RA'(MAP_W) : rs == P3 ? RA'(MAP_W + 1) : '0);
  always_comb
    rs_n = tx_done ? INI
         : rs == INI ? (rdy && !bsy_in ? P0 : INI)
         : rs == P0 ? P1 : rs == P1 ? P2 : rs == P2 ? P3
         : rs == P3 ? (nb == RA'(DEPTH) ? DONE : INI) : rs;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rs <= INI;
    else rs <= rs_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      base <= '0;
      col <= '0;
    end else if (tx_done || rs == P3) begin
      base <= tx_done ? '0 : nb;
      col <= (tx_done || col == RA'(MAP_W / 2 - 1)) ? '0 : col + 1'b1;
    end
`ifdef LAYER_CONV_MAXPOOL_EN
  logic rd_v;
  logic [1:0] rd_i, ri;
  logic [CH*ACC_W-1:0] mx, mx_n;
  assign ri = rs == P1 ? 2'd1 : rs == P2 ? 2'd2 : rs == P3 ? 2'd3 : 2'd0;
  always_comb begin
    mx_n = mx;
    for (int c = 0; c < CH; c++)
      if (rd_i == 2'd0 || $signed(q[c*ACC_W +: ACC_W]) > $signed(mx[c*ACC_W +: ACC_W]))
        mx_n[c*ACC_W +: ACC_W] = q[c*ACC_W +: ACC_W];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_v <= 1'b0;
      rd_i <= '0;
      mx <= '0;
      vld_out <= 1'b0;
    end else begin
      rd_v <= rd && !tx_done;
      rd_i <= tx_done ? 2'd0 : ri;
      vld_out <= rd_v && rd_i == 2'd3 && !tx_done;
      mx <= tx_done ? '0 : rd_v ? mx_n : mx;
    end
  assign dout = mx;
`else
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) vld_out <= 1'b0;
    else vld_out <= rd && !tx_done;
  assign dout = vld_out ? q : '0;
`endif
endmodule
